// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - multi-lane instruction decoder feeding an in-order circular queue
// Decodes up to LANES instructions per cycle and drains up to LANES in order to rename.
module decode_queue #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [LANES-1:0]         in_lane_en,
  input  logic [LANES*32-1:0]      in_instr,
  input  logic [LANES*XLEN-1:0]    in_pc,
  output logic                     in_ready,
  output logic [LANES-1:0]         out_valid,
  input  logic [LANES-1:0]         out_ready,
  output logic [LANES*5-1:0]       out_rs1,
  output logic [LANES*5-1:0]       out_rs2,
  output logic [LANES*5-1:0]       out_rd,
  output logic [LANES*3-1:0]       out_alu_op,
  output logic [LANES*7-1:0]       out_opcode,
  output logic [LANES*2-1:0]       out_fu,
  output logic [LANES*3-1:0]       out_func3,
  output logic [LANES*7-1:0]       out_func7,
  output logic [LANES*XLEN-1:0]    out_imm,
  output logic [LANES-1:0]         out_rd_wr,
  output logic [LANES-1:0]         out_illegal,
  output logic [LANES*XLEN-1:0]    out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      alu_op;
    logic [6:0]      opcode;
    logic [1:0]      fu;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] imm;
    logic            rd_wr;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } entry_t;

  function automatic entry_t decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    entry_t      e;
    logic [31:0] imm;
    logic        wr;
    e   = '0;
    imm = '0;
    wr  = 1'b0;
    case (ins[6:0])
      7'b0010011: begin
        e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.alu_op = 3'b011; e.fu = 2'b01;
        e.func3 = ins[14:12]; e.func7 = ins[31:25];
        imm = {{20{ins[31]}}, ins[31:20]}; wr = 1'b1;
      end
      7'b0110111: begin
        e.rd = ins[11:7]; e.alu_op = 3'b100; e.fu = 2'b01;
        imm = {ins[31:12], 12'b0}; wr = 1'b1;
      end
      7'b0010111: begin
        e.rd = ins[11:7]; e.alu_op = 3'b101; e.fu = 2'b01;
        imm = {ins[31:12], 12'b0}; wr = 1'b1;
      end
      7'b0110011: begin
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.alu_op = 3'b010;
        e.fu = 2'b01; e.func3 = ins[14:12]; e.func7 = ins[31:25]; wr = 1'b1;
      end
      7'b0000011: begin
        e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.alu_op = 3'b000; e.fu = 2'b11;
        e.func3 = ins[14:12];
        imm = {{20{ins[31]}}, ins[31:20]}; wr = 1'b1;
      end
      7'b0100011: begin
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.alu_op = 3'b000; e.fu = 2'b11;
        e.func3 = ins[14:12];
        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b1100011: begin
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.alu_op = 3'b001; e.fu = 2'b10;
        e.func3 = ins[14:12];
        imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b1100111: begin
        e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.alu_op = 3'b110; e.fu = 2'b10;
        e.func3 = ins[14:12];
        imm = {{20{ins[31]}}, ins[31:20]}; wr = 1'b1;
      end
      7'b1101111: begin
        e.rd = ins[11:7]; e.alu_op = 3'b111; e.fu = 2'b10;
        imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; wr = 1'b1;
      end
      default: e.illegal = 1'b1;
    endcase
    // Illegal entries report every decoded field as zero, opcode included.
    e.opcode = e.illegal ? 7'd0 : ins[6:0];
    e.imm    = XLEN'($signed(imm));
    e.rd_wr  = wr && (e.rd != 5'd0);
    e.pc     = pc;
    return e;
  endfunction

  entry_t          mem_q [DEPTH];
  entry_t          dec   [LANES];
  entry_t          head_e [LANES];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   push_n, pop_n;
  logic            push_ok;
  logic            pop_stop;

  assign in_ready = (count_q <= CW'(DEPTH - LANES));
  assign push_ok  = in_valid && in_ready && !flush;
  assign count    = count_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      dec[i] = decode(in_instr[32*i +: 32], in_pc[XLEN*i +: XLEN]);
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      out_valid[i] = (count_q > CW'(i));
    end
  end

  always_comb begin
    push_n = '0;
    if (push_ok) begin
      for (int i = 0; i < LANES; i++) begin
        push_n = push_n + CW'(in_lane_en[i]);
      end
    end
  end

  // Pops stop at the first lane rename declines; later lanes stay queued.
  always_comb begin
    pop_n    = '0;
    pop_stop = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!pop_stop && out_valid[i] && out_ready[i]) begin
        pop_n = pop_n + CW'(1);
      end else begin
        pop_stop = 1'b1;
      end
    end
  end

  always_comb begin
    head_d  = head_q + pop_n[PW-1:0];
    tail_d  = tail_q + push_n[PW-1:0];
    count_d = count_q + push_n - pop_n;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_lane_en[i]) begin
          mem_q[tail_q + PW'(i)] <= dec[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      head_e[i]                  = mem_q[head_q + PW'(i)];
      out_rs1[5*i +: 5]          = head_e[i].rs1;
      out_rs2[5*i +: 5]          = head_e[i].rs2;
      out_rd[5*i +: 5]           = head_e[i].rd;
      out_alu_op[3*i +: 3]       = head_e[i].alu_op;
      out_opcode[7*i +: 7]       = head_e[i].opcode;
      out_fu[2*i +: 2]           = head_e[i].fu;
      out_func3[3*i +: 3]        = head_e[i].func3;
      out_func7[7*i +: 7]        = head_e[i].func7;
      out_imm[XLEN*i +: XLEN]    = head_e[i].imm;
      out_rd_wr[i]               = head_e[i].rd_wr;
      out_illegal[i]             = head_e[i].illegal;
      out_pc[XLEN*i +: XLEN]     = head_e[i].pc;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - directed bench for decode_queue with a PC scoreboard
// Decode fields are checked against constants; queue order against a scoreboard of PCs.
module tb_decode_queue;

  localparam int L  = 2;
  localparam int D  = 8;
  localparam int XL = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic [L-1:0]    in_lane_en;
  logic [L*32-1:0] in_instr;
  logic [L*XL-1:0] in_pc;
  logic            in_ready;
  logic [L-1:0]    out_valid;
  logic [L-1:0]    out_ready;
  logic [L*5-1:0]  out_rs1, out_rs2, out_rd;
  logic [L*3-1:0]  out_alu_op, out_func3;
  logic [L*7-1:0]  out_opcode, out_func7;
  logic [L*2-1:0]  out_fu;
  logic [L*XL-1:0] out_imm, out_pc;
  logic [L-1:0]    out_rd_wr, out_illegal;
  logic [3:0]      count;

  int              n_vec = 0;
  int              n_err = 0;
  logic [XL-1:0]   sb[$];

  always #5 clk = ~clk;

  decode_queue #(.LANES(L), .DEPTH(D), .XLEN(XL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_lane_en(in_lane_en), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_alu_op(out_alu_op), .out_opcode(out_opcode), .out_fu(out_fu),
    .out_func3(out_func3), .out_func7(out_func7), .out_imm(out_imm),
    .out_rd_wr(out_rd_wr), .out_illegal(out_illegal), .out_pc(out_pc),
    .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: checks the pop/ready view before the edge, updates the model, checks count after.
  task automatic cycle();
    int          np;
    logic        stop;
    logic        model_ready;
    logic [L-1:0] exp_valid;
    #1;
    model_ready = ((D - sb.size()) >= L);
    for (int l = 0; l < L; l++) exp_valid[l] = (sb.size() > l);
    chk("out_valid", out_valid, exp_valid);
    chk("in_ready", in_ready, model_ready);
    np   = 0;
    stop = 1'b0;
    if (!flush) begin
      for (int l = 0; l < L; l++) begin
        if (!stop && sb.size() > l && out_ready[l]) begin
          chk($sformatf("pop_pc_lane%0d", l), out_pc[XL*l +: XL], sb[l]);
          np++;
        end else begin
          stop = 1'b1;
        end
      end
      for (int k = 0; k < np; k++) void'(sb.pop_front());
      if (in_valid && model_ready) begin
        for (int l = 0; l < L; l++) if (in_lane_en[l]) sb.push_back(in_pc[XL*l +: XL]);
      end
    end else begin
      sb.delete();
    end
    @(posedge clk);
    #1;
    chk("count", count, sb.size());
  endtask

  task automatic drive(input logic [1:0] en, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] pc0);
    in_valid   = 1'b1;
    in_lane_en = en;
    in_instr   = {i1, i0};
    in_pc      = {pc0 + 32'd4, pc0};
  endtask

  task automatic idle_in();
    in_valid   = 1'b0;
    in_lane_en = '0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_lane_en = '0;
    in_instr = '0; in_pc = '0; out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", count, 0);
    chk("reset_out_valid", out_valid, 2'b00);
    chk("reset_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    cycle();

    // addi x1,x0,5 ; add x3,x1,x2
    drive(2'b11, 32'h00500093, 32'h002081B3, 32'h100);
    cycle();
    idle_in();
    chk("addi_rs1", out_rs1[4:0], 0);
    chk("addi_rd", out_rd[4:0], 1);
    chk("addi_alu", out_alu_op[2:0], 3'b011);
    chk("addi_fu", out_fu[1:0], 2'b01);
    chk("addi_imm", out_imm[31:0], 5);
    chk("addi_rd_wr", out_rd_wr[0], 1'b1);
    chk("add_rs1", out_rs1[9:5], 1);
    chk("add_rs2", out_rs2[9:5], 2);
    chk("add_rd", out_rd[9:5], 3);
    chk("add_alu", out_alu_op[5:3], 3'b010);
    chk("add_func7", out_func7[13:7], 0);
    chk("add_imm", out_imm[63:32], 0);
    out_ready = 2'b11;
    cycle();
    out_ready = 2'b00;

    // illegal word ; jal x0,0
    drive(2'b11, 32'hFFFFFFFF, 32'h0000006F, 32'h200);
    cycle();
    idle_in();
    chk("ill_flag", out_illegal[0], 1'b1);
    chk("ill_fu", out_fu[1:0], 2'b00);
    chk("ill_fields", {out_rs1[4:0], out_rs2[4:0], out_rd[4:0], out_alu_op[2:0],
                       out_func3[2:0], out_func7[6:0], out_rd_wr[0]}, 0);
    chk("ill_imm", out_imm[31:0], 0);
    chk("jal_alu", out_alu_op[5:3], 3'b111);
    chk("jal_fu", out_fu[3:2], 2'b10);
    chk("jal_rd_wr", out_rd_wr[1], 1'b0);
    chk("jal_illegal", out_illegal[1], 1'b0);
    out_ready = 2'b11;
    cycle();
    out_ready = 2'b00;

    // auipc x1,0x12345 ; beq x1,x2,-4
    drive(2'b11, 32'h12345097, 32'hFE208EE3, 32'h300);
    cycle();
    idle_in();
    chk("auipc_imm", out_imm[31:0], 32'h12345000);
    chk("auipc_alu", out_alu_op[2:0], 3'b101);
    chk("auipc_rd_wr", out_rd_wr[0], 1'b1);
    chk("beq_imm", out_imm[63:32], 32'hFFFFFFFC);
    chk("beq_fu_alu", {out_fu[3:2], out_alu_op[5:3]}, {2'b10, 3'b001});
    chk("beq_rd_wr", out_rd_wr[1], 1'b0);
    out_ready = 2'b11;
    cycle();
    out_ready = 2'b00;

    // Fill with rename stalled; tail wraps past the end of the ring.
    for (int g = 0; g < 3; g++) begin
      drive(2'b11, 32'h00000013, 32'h00000013, 32'h400 + 32'(g * 8));
      cycle();
    end
    drive(2'b01, 32'h00000013, 32'h00000013, 32'h418);
    cycle();
    chk("full_count", count, 7);
    chk("full_in_ready", in_ready, 1'b0);
    drive(2'b11, 32'h00000013, 32'h00000013, 32'h500);
    cycle();
    idle_in();
    out_ready = 2'b01;
    for (int k = 0; k < 7; k++) cycle();
    chk("drained_count", count, 0);
    out_ready = 2'b00;

    // Reach count=4, then push 2 and pop 2 together.
    drive(2'b11, 32'h00000013, 32'h00000013, 32'h600);
    cycle();
    drive(2'b11, 32'h00000013, 32'h00000013, 32'h608);
    cycle();
    drive(2'b11, 32'h00000013, 32'h00000013, 32'h610);
    out_ready = 2'b11;
    cycle();
    chk("simul_count", count, 4);
    chk("simul_head_pc", out_pc[31:0], 32'h608);
    drive(2'b11, 32'h00000013, 32'h00000013, 32'h618);
    cycle();
    chk("simul_head_pc2", out_pc[31:0], 32'h610);
    out_ready = 2'b00;

    // count=5, then flush alongside an incoming group.
    drive(2'b01, 32'h00000013, 32'h00000013, 32'h620);
    cycle();
    chk("preflush_count", count, 5);
    drive(2'b11, 32'h00000013, 32'h00000013, 32'h700);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    idle_in();
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 2'b00);
    cycle();
    chk("post_flush_count", count, 0);

    // Asynchronous reset mid-operation.
    drive(2'b11, 32'h00000013, 32'h00000013, 32'h800);
    cycle();
    idle_in();
    chk("pre_reset_count", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("async_reset_count", count, 0);
    chk("async_reset_valid", out_valid, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
